fp_adder_stage3_normalize: RTL and testbench

Post-add normalization stage of the FP adder pipeline. It consumes the significand sum and carry-out produced by the significand-add stage, together with the common (larger) exponent and the result sign. It renormalizes the significand: a right shift on carry, or an iterative one-bit-per-cycle left shift on leading zeros. It then adjusts the exponent, detects overflow, underflow and zero, and packs the final IEEE-754 word behind a valid/ready handshake.

---
 rtl/fp_adder_stage3_normalize.sv | 153 +++++++++++++++
 tb/tb_fp_adder_stage3_normalize.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_adder_stage3_normalize.sv
`default_nettype none
// ============================================================================
// fp_adder_stage3_normalize: post-add renormalize, exponent adjust, pack.
// Revision 1.0
// ============================================================================
module fp_adder_stage3_normalize #(
  parameter int FP_SIZE   = 32,
  parameter int FRAC_SIZE = 23
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             sign_in,
  input  logic [FP_SIZE-FRAC_SIZE-2:0]     exponent_in,
  input  logic [FRAC_SIZE:0]               significand_in,
  input  logic                             carryout_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FP_SIZE-1:0]               result,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             zero
);

  localparam int EXP_SIZE = FP_SIZE - FRAC_SIZE - 1;
  localparam logic [EXP_SIZE-1:0] EXP_ONES = {EXP_SIZE{1'b1}};
  localparam logic [EXP_SIZE-1:0] EXP_ONE  = EXP_SIZE'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [EXP_SIZE-1:0]   exp_q, exp_d;
  logic [FRAC_SIZE:0]    sig_q, sig_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  zero_q, zero_d;

  logic [EXP_SIZE-1:0]   exp_inc;
  logic                  accept;

  assign exp_inc = exponent_in + EXP_ONE;
  assign accept  = in_valid && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    sig_d       = sig_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d      = sign_in;
          exp_d       = exponent_in;
          sig_d       = significand_in;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          zero_d      = 1'b0;
          if (exponent_in == EXP_ONES) begin
            state_d = DONE;
          end else if (carryout_in) begin
            // Truncating right shift; the carry becomes the new hidden bit.
            sig_d   = {1'b1, significand_in[FRAC_SIZE:1]};
            exp_d   = exp_inc;
            state_d = DONE;
            if (exp_inc == EXP_ONES) begin
              overflow_d = 1'b1;
              sig_d      = '0;
            end
          end else if (significand_in == '0) begin
            sign_d  = 1'b0;
            exp_d   = '0;
            sig_d   = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else if (significand_in[FRAC_SIZE]) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Hidden bit is always clear here; exponent 0 (denormal input) flushes too.
        if (exp_q <= EXP_ONE) begin
          exp_d       = '0;
          sig_d       = '0;
          underflow_d = 1'b1;
          zero_d      = 1'b1;
          state_d     = DONE;
        end else begin
          sig_d = {sig_q[FRAC_SIZE-1:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
          if (sig_q[FRAC_SIZE-1]) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          zero_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      sig_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = {sign_q, exp_q, sig_q[FRAC_SIZE-1:0]};
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_adder_stage3_normalize.sv
`default_nettype none
// ============================================================================
// tb_fp_adder_stage3_normalize: directed and randomized checks against a model.
// Revision 1.0
// ============================================================================
module tb_fp_adder_stage3_normalize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sign_in = 1'b0;
  logic        carryout_in = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  exponent_in = '0;
  logic [23:0] significand_in = '0;
  logic        in_ready, out_valid, overflow, underflow, zero;
  logic [31:0] result;

  fp_adder_stage3_normalize #(.FP_SIZE(32), .FRAC_SIZE(23)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exponent_in(exponent_in),
    .significand_in(significand_in), .carryout_in(carryout_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_last = 0;
  bit seen = 0;
  bit rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        un;
    logic        z;
    int          k;
    int          acc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Expected outcome from value arithmetic: leading-one search, exponent budget.
  function automatic exp_t model(logic s, logic [7:0] e, logic [23:0] sig, logic c);
    exp_t        r;
    int          p;
    int          sh;
    logic [24:0] sum;
    logic [23:0] nsig;
    r = '{res: 32'h0, ov: 1'b0, un: 1'b0, z: 1'b0, k: 0, acc: 0};
    if (e == 8'hFF) begin
      r.res = {s, e, sig[22:0]};
    end else if (c) begin
      sum = {1'b1, sig} >> 1;
      if (int'(e) + 1 == 255) begin
        r.res = {s, 8'hFF, 23'h0};
        r.ov  = 1'b1;
      end else begin
        r.res = {s, e + 8'd1, sum[22:0]};
      end
    end else if (sig == 24'h0) begin
      r.res = 32'h0;
      r.z   = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (sig[i]) p = i;
      sh = 23 - p;
      if (sh == 0) begin
        r.res = {s, e, sig[22:0]};
      end else if (int'(e) > sh) begin
        nsig  = sig << sh;
        r.res = {s, 8'(int'(e) - sh), nsig[22:0]};
        r.k   = sh;
      end else begin
        r.res = {s, 31'h0};
        r.un  = 1'b1;
        r.z   = 1'b1;
        r.k   = (e == 8'h0) ? 1 : int'(e);
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, q.size() == 0);
      if (!out_valid) begin
        chk("idle_flags", {overflow, underflow, zero}, 3'b000);
      end else if (q.size() == 0) begin
        chk("spurious_valid", out_valid, 1'b0);
      end else begin
        if (!seen) begin
          chk("latency", cyc - q[0].acc, q[0].k);
          seen = 1;
        end
        chk("result", result, q[0].res);
        chk("flags", {overflow, underflow, zero}, {q[0].ov, q[0].un, q[0].z});
        if (out_ready) begin
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] sig, input logic c);
    exp_t x;
    int   n = 0;
    sign_in = s; exponent_in = e; significand_in = sig; carryout_in = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      x = model(s, e, sig, c);
      x.acc = cyc;
      acc_last = cyc;
      q.push_back(x);
      in_valid = 1'b0;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] res, input logic [2:0] flg, input int lat);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_result"}, result, res);
    chk({nm, "_flags"}, {overflow, underflow, zero}, flg);
    chk({nm, "_latency"}, cyc - acc_last, lat);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {out_valid, result, overflow, underflow, zero}, 36'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    send(1'b0, 8'd127, 24'h000000, 1'b1);
    lit("carry", 32'h40000000, 3'b000, 0);

    send(1'b0, 8'd127, 24'hC00000, 1'b0);
    lit("normalized", 32'h3FC00000, 3'b000, 0);

    send(1'b0, 8'd127, 24'h200000, 1'b0);
    sign_in = 1'b1; exponent_in = 8'd3; significand_in = 24'hC00000; carryout_in = 1'b0;
    in_valid = 1'b1;
    chk("busy_n1", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("busy_n2", in_ready, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_n3", in_ready, 1'b0);
    acc_last = acc_last + 2;
    lit("shift2", 32'h3E800000, 3'b000, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("no_second_accept", out_valid, 1'b0);

    out_ready = 1'b0;
    send(1'b1, 8'd100, 24'h000000, 1'b0);
    lit("cancel", 32'h00000000, 3'b001, 0);
    repeat (3) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", {result, zero}, 33'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", {in_ready, out_valid, zero}, 3'b100);

    send(1'b0, 8'd254, 24'h000000, 1'b1);
    lit("overflow", 32'h7F800000, 3'b100, 0);

    send(1'b1, 8'd5, 24'h000001, 1'b0);
    lit("underflow", 32'h80000000, 3'b011, 5);

    send(1'b1, 8'd5, 24'h000001, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q.delete();
    seen = 0;
    #1;
    chk("midrst_outputs", {out_valid, result, overflow, underflow, zero}, 36'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("after_rst_idle", {in_ready, out_valid}, 2'b10);

    rnd_rdy = 1;
    for (int t = 0; t < 300; t++) begin
      logic [7:0]  e;
      logic [23:0] sig;
      logic        c;
      case ($urandom_range(0, 5))
        0: e = 8'($urandom_range(0, 3));
        1: e = 8'hFF;
        2: e = 8'hFE;
        3: e = 8'($urandom_range(4, 30));
        default: e = 8'($urandom_range(0, 254));
      endcase
      sig = 24'($urandom) >> $urandom_range(0, 24);
      c = ($urandom_range(0, 3) == 0);
      send(1'($urandom), e, sig, c);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rnd_rdy = 0;
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
